// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the data-memory read arbiter (mem_rd_arbiter).
// Tag width is sized for the largest supported requester count (16).
package mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int MAX_REQ = 16;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      size;
        logic [1:0]      offset;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // One-hot to index; an all-zero input yields 0.
    function automatic logic [ID_W-1:0] encoder(input logic [MAX_REQ-1:0] onehot);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) idx = idx | ID_W'(i);
        end
        return idx;
    endfunction

    // Extracts the addressed byte/half from a raw word and sign-extends it.
    function automatic logic [31:0] rdata_gen(input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  offset);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{offset, 3'b000} +: 8];
        h = offset[1] ? data[31:16] : data[15:0];
        if (size == SZ_BYTE)      return {{24{b[7]}}, b};
        else if (size == SZ_HALF) return {{16{h[15]}}, h};
        else                      return data;
    endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order tag FIFO for outstanding reads; full/empty derive from the
// registered count only, so a same-cycle pop never frees a slot for a push.
module mem_arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory read port among NUM_REQ loaders.
// Define MEM_ARB_QOS_EN to give requester 0 fixed top priority.
module mem_rd_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*2-1:0]      req_size,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [31:0]               rsp_data,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_rsp_valid,
    input  logic [31:0]               mem_rsp_data
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   idx;
    logic [NUM_REQ-1:0] rr_oh;
    logic               rr_found;
    logic [ID_W-1:0]    rr_id;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    lock_id;
    logic               locked;
    logic [ADDR_W-1:0]  grant_addr;
    logic [1:0]         grant_size;
    logic               accept;
    logic               fifo_full;
    logic               fifo_empty;
    logic               rsp_fire;
    tag_t               push_tag;
    tag_t               pop_tag;

    // First valid requester scanning from ptr with wrap-around.
    always_comb begin
        rr_oh    = '0;
        rr_found = 1'b0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!rr_found && req_valid[idx]) begin
                rr_oh[idx] = 1'b1;
                rr_found   = 1'b1;
            end
        end
        rr_id = encoder(MAX_REQ'(rr_oh));
    end

    always_comb begin
        if (locked)
            grant_id = lock_id;
`ifdef MEM_ARB_QOS_EN
        else if (req_valid[0])
            grant_id = '0;
`endif
        else
            grant_id = rr_id;
    end

    always_comb begin
        grant_addr = '0;
        grant_size = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                grant_addr = req_addr[i*ADDR_W +: ADDR_W];
                grant_size = req_size[i*2 +: 2];
            end
        end
    end

    // Handshakes: a transfer happens only in a cycle where valid and ready are
    // both high; once valid is raised, the source holds it and its payload
    // stable until that cycle. rsp_valid is a one-cycle strobe with no ready.
    assign mem_req_valid = (|req_valid) & ~fifo_full & ~rst;
    assign accept        = mem_req_valid & mem_req_ready;
    assign req_ready     = accept ? (NUM_REQ'(1) << grant_id) : '0;
    assign mem_addr      = {grant_addr[ADDR_W-1:2], 2'b00};
    assign push_tag      = '{id: grant_id, size: grant_size, offset: grant_addr[1:0]};
    assign rsp_fire      = mem_rsp_valid & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (accept) begin
            locked <= 1'b0;
`ifdef MEM_ARB_QOS_EN
            if (grant_id != '0)
                ptr <= PTR_W'((int'(grant_id) + 1) % NUM_REQ);
`else
            ptr <= PTR_W'((int'(grant_id) + 1) % NUM_REQ);
`endif
        end else if (mem_req_valid) begin
            locked  <= 1'b1;
            lock_id <= grant_id;
        end
    end

    mem_arb_tag_fifo #(
        .DEPTH (OUTSTANDING),
        .W     (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_tag),
        .pop       (mem_rsp_valid),
        .pop_data  (pop_tag),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rsp_fire ? (NUM_REQ'(1) << pop_tag.id) : '0;
            if (rsp_fire)
                rsp_data <= rdata_gen(mem_rsp_data, pop_tag.size, pop_tag.offset);
        end
    end

    // A response with nothing outstanding is dropped; flag it in simulation.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_rsp_valid && fifo_empty))
                else $warning("mem_rd_arbiter: read response with empty tag FIFO dropped");
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: vector table for alignment plus
// hand-written sequences for rotation, lock, full, priority and reset.
module tb_mem_rd_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 32;
    localparam int OUTSTANDING = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*2-1:0]      req_size;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [31:0]               rsp_data;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_rsp_valid;
    logic [31:0]               mem_rsp_data;

    always #5 clk = ~clk;

    mem_rd_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .OUTSTANDING (OUTSTANDING)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    typedef struct {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [1:0]  size;
        int          delay;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  exp_q [$];
    logic        push_pend = 1'b0;
    logic [1:0]  push_id = '0;
    logic [31:0] exp_rsp_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; score any response due from the edge just taken.
    task automatic tick();
        logic        had_rsp;
        logic        in_rst;
        logic        had_push;
        logic [1:0]  pid;
        logic [1:0]  id;
        logic [31:0] want;
        had_rsp  = mem_rsp_valid;
        in_rst   = rst;
        had_push = push_pend;
        pid      = push_id;
        want     = exp_rsp_data;
        @(posedge clk);
        #1;
        push_pend = 1'b0;
        if (in_rst) begin
            exp_q.delete();
            check("rsp_valid_in_reset", 32'(rsp_valid), 32'h0);
        end else begin
            if (had_rsp && exp_q.size() > 0) begin
                id = exp_q.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(1) << id);
                check("rsp_data", rsp_data, want);
            end else begin
                check("rsp_valid_idle", 32'(rsp_valid), 32'h0);
            end
            if (had_push) exp_q.push_back(pid);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] addr, input logic [1:0] size);
        req_valid[id]           = 1'b1;
        req_addr[id*32 +: 32]   = addr;
        req_size[id*2 +: 2]     = size;
    endtask

    task automatic mem_return(input logic [31:0] data, input logic [31:0] exp);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        exp_rsp_data  = exp;
    endtask

    task automatic expect_grant(input string name, input int g, input logic [31:0] addr);
        #1;
        check({name, "_valid"}, 32'(mem_req_valid), 32'h1);
        check({name, "_ready"}, 32'(req_ready), 32'(1) << g);
        check({name, "_addr"}, mem_addr, addr);
        push_pend = 1'b1;
        push_id   = 2'(g);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        req_valid     = '1;
        #1;
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        tick();
        tick();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check("rst_rsp_data", rsp_data, 32'h0);
        check("idle_mem_req_valid", 32'(mem_req_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst           = 1'b1;
        req_valid     = '0;
        req_addr      = '0;
        req_size      = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;

        vecs[0] = '{2'd1, 32'h0000_0103, 2'b00, 2, 32'h80FF_1234, 32'hFFFF_FF80};
        vecs[1] = '{2'd0, 32'h0000_0002, 2'b01, 0, 32'h8001_7FFF, 32'hFFFF_8001};
        vecs[2] = '{2'd2, 32'h0000_0004, 2'b10, 0, 32'h8001_7FFF, 32'h8001_7FFF};
        vecs[3] = '{2'd3, 32'h0000_0201, 2'b00, 1, 32'h1234_5678, 32'h0000_0056};
        vecs[4] = '{2'd0, 32'h0000_0010, 2'b01, 0, 32'h1234_8765, 32'hFFFF_8765};
        vecs[5] = '{2'd1, 32'h0000_0033, 2'b01, 0, 32'h7ABC_0000, 32'h0000_7ABC};
        vecs[6] = '{2'd2, 32'h0000_0040, 2'b00, 0, 32'h0000_00FF, 32'hFFFF_FFFF};
        vecs[7] = '{2'd3, 32'h0000_0008, 2'b11, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

        do_reset();

        // Single loads: alignment, sign extension, response routing.
        foreach (vecs[k]) begin
            req_valid = '0;
            set_req(vecs[k].id, vecs[k].addr, vecs[k].size);
            expect_grant("vec", vecs[k].id, {vecs[k].addr[31:2], 2'b00});
            tick();
            req_valid = '0;
            repeat (vecs[k].delay) tick();
            mem_return(vecs[k].data, vecs[k].exp);
            tick();
            mem_rsp_valid = 1'b0;
        end
        tick();

        // All requesters valid: rotation with one response per cycle.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h1000 + 32'(i) * 32'h11, 2'b10);
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_QOS_EN
            g = 0;
`else
            g = k % NUM_REQ;
`endif
            if (k > 0) mem_return(32'hA000_0000 + 32'(k), 32'hA000_0000 + 32'(k));
            expect_grant("rr", g, 32'h1000 + 32'(g) * 32'h10);
            tick();
        end
        req_valid = '0;
        mem_return(32'hA000_0006, 32'hA000_0006);
        tick();
        mem_rsp_valid = 1'b0;
        tick();

        // Stalled request stays locked on requester 2 despite requester 1.
        do_reset();
        mem_req_ready = 1'b0;
        set_req(2, 32'h0000_02A8, 2'b10);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) set_req(1, 32'h0000_0150, 2'b10);
            #1;
            check("lock_valid", 32'(mem_req_valid), 32'h1);
            check("lock_ready", 32'(req_ready), 32'h0);
            check("lock_addr", mem_addr, 32'h0000_02A8);
            tick();
        end
        mem_req_ready = 1'b1;
        expect_grant("lock_accept", 2, 32'h0000_02A8);
        tick();
        req_valid[2] = 1'b0;
        expect_grant("after_lock", 1, 32'h0000_0150);
        tick();
        req_valid = '0;
        mem_return(32'h1111_2222, 32'h1111_2222);
        tick();
        mem_return(32'h3333_4444, 32'h3333_4444);
        tick();
        mem_rsp_valid = 1'b0;

        // Fill all outstanding slots, then one response reopens issuing.
        do_reset();
        set_req(1, 32'h0000_1104, 2'b10);
        set_req(2, 32'h0000_2208, 2'b10);
        for (int k = 0; k < OUTSTANDING; k++) begin
            g = (k % 2 == 0) ? 1 : 2;
            expect_grant("fill", g, (g == 1) ? 32'h0000_1104 : 32'h0000_2208);
            tick();
        end
        #1;
        check("full_mem_req_valid", 32'(mem_req_valid), 32'h0);
        check("full_req_ready", 32'(req_ready), 32'h0);
        mem_return(32'h5555_AAAA, 32'h5555_AAAA);
        tick();
        mem_rsp_valid = 1'b0;
        expect_grant("resume", 1, 32'h0000_1104);
        tick();
        req_valid = '0;
        for (int k = 0; k < OUTSTANDING; k++) begin
            mem_return(32'h6000_0000 + 32'(k), 32'h6000_0000 + 32'(k));
            tick();
        end
        mem_rsp_valid = 1'b0;
        tick();

        // Pointer at 3, then requesters 0 and 3 contend.
        do_reset();
        set_req(2, 32'h0000_0300, 2'b10);
        expect_grant("ptr_setup", 2, 32'h0000_0300);
        tick();
        req_valid = '0;
        set_req(0, 32'h0000_0400, 2'b10);
        set_req(3, 32'h0000_0500, 2'b10);
`ifdef MEM_ARB_QOS_EN
        expect_grant("prio", 0, 32'h0000_0400);
`else
        expect_grant("prio", 3, 32'h0000_0500);
`endif
        tick();
        req_valid = '0;
        set_req(1, 32'h0000_0600, 2'b10);
        set_req(3, 32'h0000_0500, 2'b10);
`ifdef MEM_ARB_QOS_EN
        expect_grant("ptr_after_prio", 3, 32'h0000_0500);
`else
        expect_grant("ptr_after_prio", 1, 32'h0000_0600);
`endif
        tick();
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            mem_return(32'h7000_0000 + 32'(k), 32'h7000_0000 + 32'(k));
            tick();
        end
        mem_rsp_valid = 1'b0;

        // Reset with two reads in flight drops them; a late response is ignored.
        do_reset();
        set_req(0, 32'h0000_0010, 2'b10);
        expect_grant("inflight0", 0, 32'h0000_0010);
        tick();
        req_valid = '0;
        set_req(1, 32'h0000_0020, 2'b10);
        expect_grant("inflight1", 1, 32'h0000_0020);
        tick();
        req_valid = '0;
        rst = 1'b1;
        mem_return(32'h1234_5678, 32'h1234_5678);
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        rst = 1'b0;
        mem_return(32'hCAFE_F00D, 32'hCAFE_F00D);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check("post_rst_rsp_data", rsp_data, 32'h0);
        set_req(3, 32'h0000_0044, 2'b10);
        expect_grant("post_rst", 3, 32'h0000_0044);
        tick();
        req_valid = '0;
        mem_return(32'h0BAD_F00D, 32'h0BAD_F00D);
        tick();
        mem_rsp_valid = 1'b0;
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
